// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: accepts a byte, drives the external serializer and
// muxes start/data/parity/stop bits onto the line, one bit per clk.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_data,
    output logic                  data_ready,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_pdata,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    state_t                line_sel_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  par_en_r;
    logic                  parity_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic                  stop_cnt_r;
    logic                  stop_last_s;
    logic                  accept_s;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Next-state decode and the ready handshake.
    always_comb begin
        next_state_s = state_r;
        data_ready   = 1'b0;
        stop_last_s  = (stop_cnt_r == STOP_LAST);
        case (state_r)
            S_IDLE: begin
                data_ready = 1'b1;
                if (data_valid) next_state_s = S_START;
                else            next_state_s = S_IDLE;
            end
            S_START:  next_state_s = S_DATA;
            S_DATA: begin
                if (bit_cnt_r == BIT_LAST) begin
                    if (par_en_r) next_state_s = S_PARITY;
                    else          next_state_s = S_STOP;
                end else begin
                    next_state_s = S_DATA;
                end
            end
            S_PARITY: next_state_s = S_STOP;
            S_STOP: begin
                if (stop_last_s) begin
                    // Back-to-back frames: a new byte can go straight to START.
                    data_ready = 1'b1;
                    if (data_valid) next_state_s = S_START;
                    else            next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_STOP;
                end
            end
            default:  next_state_s = S_IDLE;
        endcase
        accept_s = data_valid && data_ready;
    end

    // State register and line-select delay stage that aligns with the serializer output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            line_sel_r <= S_IDLE;
        end else begin
            state_r    <= next_state_s;
            line_sel_r <= state_r;
        end
    end

    // Data bit and stop bit counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r  <= {CNT_W{1'b0}};
            stop_cnt_r <= 1'b0;
        end else begin
            if (state_r == S_DATA) bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            else                   bit_cnt_r <= {CNT_W{1'b0}};
            if ((state_r == S_STOP) && !stop_last_s) stop_cnt_r <= stop_cnt_r + 1'b1;
            else                                     stop_cnt_r <= 1'b0;
        end
    end

    // Byte, parity enable and parity bit captured on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r   <= {DATA_WIDTH{1'b0}};
            par_en_r <= 1'b0;
            parity_r <= 1'b0;
        end else if (accept_s) begin
            data_r   <= P_DATA;
            par_en_r <= par_en;
            parity_r <= calc_parity(P_DATA, par_typ);
        end else begin
            data_r   <= data_r;
            par_en_r <= par_en_r;
            parity_r <= parity_r;
        end
    end

    assign ser_en    = (state_r == S_DATA);
    assign ser_pdata = data_r;
    assign busy      = (state_r != S_IDLE) || (line_sel_r != S_IDLE);

    // Line multiplexer driven by the delayed state.
    always_comb begin
        tx_out = 1'b1;
        case (line_sel_r)
            S_IDLE:   tx_out = 1'b1;
            S_START:  tx_out = 1'b0;
            S_DATA:   tx_out = ser_data;
            S_PARITY: tx_out = parity_r;
            S_STOP:   tx_out = 1'b1;
            default:  tx_out = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (1 and 2 stop bits), serializer models and
// a per-line-bit scoreboard filled at accept time.
module tb_uart_tx_ctrl;

    typedef struct packed {
        logic val;
        logic is_data;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dv;
    logic [7:0] p_data;
    logic       par_en;
    logic       par_typ;
    logic       sd0, sd1;
    logic [7:0] sr0, sr1;
    wire  [1:0] rdy, en, txo, bsy;
    wire  [7:0] pdata0, pdata1;

    item_t       exp_q [2][$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] tx_c, en_c, bz_c, rd_c;

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .data_valid(dv[0]), .P_DATA(p_data), .par_en(par_en),
        .par_typ(par_typ), .ser_data(sd0), .data_ready(rdy[0]), .ser_en(en[0]),
        .ser_pdata(pdata0), .tx_out(txo[0]), .busy(bsy[0])
    );

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .data_valid(dv[1]), .P_DATA(p_data), .par_en(par_en),
        .par_typ(par_typ), .ser_data(sd1), .data_ready(rdy[1]), .ser_en(en[1]),
        .ser_pdata(pdata1), .tx_out(txo[1]), .busy(bsy[1])
    );

    always #5 clk = ~clk;

    // Serializer models: reload while ser_en low, shift LSB first with a registered output.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sr0 <= 8'h00; sd0 <= 1'b0;
        end else if (!en[0]) begin
            sr0 <= pdata0;
        end else begin
            sd0 <= sr0[0]; sr0 <= {1'b0, sr0[7:1]};
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sr1 <= 8'h00; sd1 <= 1'b0;
        end else if (!en[1]) begin
            sr1 <= pdata1;
        end else begin
            sd1 <= sr1[0]; sr1 <= {1'b0, sr1[7:1]};
        end
    end

    // One clock: compare both DUTs against the scoreboard at negedge, record accepts.
    task automatic step_cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic  exp_tx, exp_busy, exp_en, exp_rdy;
            item_t it;
            int    ones;
            if (rst) exp_q[k].delete();
            exp_busy = (exp_q[k].size() != 0);
            exp_tx   = (exp_q[k].size() != 0) ? exp_q[k][0].val : 1'b1;
            exp_en   = (exp_q[k].size() > 1) ? exp_q[k][1].is_data : 1'b0;
            exp_rdy  = (exp_q[k].size() <= 2);
            n_checks += 4;
            if (txo[k] !== exp_tx) begin
                n_fail++; $display("FAIL sb_tx dut%0d t=%0t got %b exp %b", k, $time, txo[k], exp_tx);
            end
            if (bsy[k] !== exp_busy) begin
                n_fail++; $display("FAIL sb_busy dut%0d t=%0t got %b exp %b", k, $time, bsy[k], exp_busy);
            end
            if (en[k] !== exp_en) begin
                n_fail++; $display("FAIL sb_ser_en dut%0d t=%0t got %b exp %b", k, $time, en[k], exp_en);
            end
            if (rdy[k] !== exp_rdy) begin
                n_fail++; $display("FAIL sb_ready dut%0d t=%0t got %b exp %b", k, $time, rdy[k], exp_rdy);
            end
            if (exp_q[k].size() != 0) void'(exp_q[k].pop_front());
            if (dv[k] && exp_rdy && !rst) begin
                it.is_data = 1'b0; it.val = 1'b1;
                while (exp_q[k].size() < 1) exp_q[k].push_back(it);
                it.val = 1'b0;
                exp_q[k].push_back(it);
                ones = 0;
                for (int b = 0; b < 8; b++) begin
                    it.val = p_data[b]; it.is_data = 1'b1;
                    exp_q[k].push_back(it);
                    if (p_data[b]) ones++;
                end
                it.is_data = 1'b0;
                if (par_en) begin
                    it.val = ((ones % 2) == 1) ^ par_typ;
                    exp_q[k].push_back(it);
                end
                it.val = 1'b1;
                for (int s = 0; s < k + 1; s++) exp_q[k].push_back(it);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one byte to DUT k, scramble the inputs after accept, capture ncyc samples.
    task automatic send_frame(input int k, input logic [7:0] d, input logic pe, input logic pt,
                              input int ncyc);
        int guard = 0;
        while (exp_q[k].size() != 0 && guard < 50) begin
            step_cycle();
            guard++;
        end
        n_checks++;
        if (exp_q[k].size() != 0) begin
            n_fail++; $display("FAIL send_wait dut%0d got %0d pending exp 0", k, exp_q[k].size());
        end
        dv[k] = 1'b1; p_data = d; par_en = pe; par_typ = pt;
        step_cycle();
        dv[k] = 1'b0; p_data = ~d; par_en = ~pe; par_typ = ~pt;
        tx_c = 32'h0; en_c = 32'h0; bz_c = 32'h0; rd_c = 32'h0;
        for (int i = 0; i < ncyc; i++) begin
            if (i != 0) step_cycle();
            tx_c[i] = txo[k]; en_c[i] = en[k]; bz_c[i] = bsy[k]; rd_c[i] = rdy[k];
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            n_checks += 4;
            if (txo[k] !== 1'b1) begin n_fail++; $display("FAIL reset_tx dut%0d got %b exp 1", k, txo[k]); end
            if (bsy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d got %b exp 0", k, bsy[k]); end
            if (rdy[k] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d got %b exp 1", k, rdy[k]); end
            if (en[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ser_en dut%0d got %b exp 0", k, en[k]); end
        end
        n_checks += 2;
        if (pdata0 !== 8'h00) begin n_fail++; $display("FAIL reset_pdata dut0 got %h exp 00", pdata0); end
        if (pdata1 !== 8'h00) begin n_fail++; $display("FAIL reset_pdata dut1 got %h exp 00", pdata1); end
        @(posedge clk);
        #1 rst = 1'b0;
        step_cycle();
        step_cycle();
    endtask

    task automatic test_basic();
        logic [9:0] exp_a5;
        exp_a5 = 10'b11_0100_1010;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 14);
        n_checks += 6;
        if (tx_c[0] !== 1'b1) begin n_fail++; $display("FAIL a5_pre_start got %b exp 1", tx_c[0]); end
        if (tx_c[10:1] !== exp_a5) begin n_fail++; $display("FAIL a5_line got %b exp %b", tx_c[10:1], exp_a5); end
        if (en_c[8:1] !== 8'hFF) begin n_fail++; $display("FAIL a5_ser_en_window got %b exp 11111111", en_c[8:1]); end
        if ($countones(en_c[13:0]) != 8) begin
            n_fail++; $display("FAIL a5_ser_en_count got %0d exp 8", $countones(en_c[13:0]));
        end
        if (bz_c[10] !== 1'b1) begin n_fail++; $display("FAIL a5_busy_10 got %b exp 1", bz_c[10]); end
        if (bz_c[11] !== 1'b0) begin n_fail++; $display("FAIL a5_busy_11 got %b exp 0", bz_c[11]); end
    endtask

    task automatic test_parity();
        logic [7:0] d_tab [3];
        logic       t_tab [3];
        logic       p_tab [3];
        d_tab = '{8'h03, 8'h03, 8'h07};
        t_tab = '{1'b0, 1'b1, 1'b0};
        p_tab = '{1'b0, 1'b1, 1'b1};
        for (int n = 0; n < 3; n++) begin
            send_frame(0, d_tab[n], 1'b1, t_tab[n], 15);
            n_checks += 4;
            if (tx_c[10] !== p_tab[n]) begin
                n_fail++; $display("FAIL parity_bit case%0d got %b exp %b", n, tx_c[10], p_tab[n]);
            end
            if (tx_c[11] !== 1'b1) begin n_fail++; $display("FAIL parity_stop case%0d got %b exp 1", n, tx_c[11]); end
            if (bz_c[11] !== 1'b1) begin n_fail++; $display("FAIL parity_busy_11 case%0d got %b exp 1", n, bz_c[11]); end
            if (bz_c[12] !== 1'b0) begin n_fail++; $display("FAIL parity_busy_12 case%0d got %b exp 0", n, bz_c[12]); end
        end
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        while (exp_q[0].size() != 0 && guard < 50) begin step_cycle(); guard++; end
        dv[0] = 1'b1; p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0;
        step_cycle();
        p_data = 8'hF0;
        tx_c = 32'h0; rd_c = 32'h0;
        for (int i = 0; i < 24; i++) begin
            if (i != 0) step_cycle();
            tx_c[i] = txo[0]; rd_c[i] = rdy[0];
            if (i == 10) dv[0] = 1'b0;
        end
        n_checks += 5;
        if (rd_c[10:0] !== 11'b010_0000_0000) begin
            n_fail++; $display("FAIL b2b_ready_pulse got %b exp 01000000000", rd_c[10:0]);
        end
        if (tx_c[9:2] !== 8'h55) begin n_fail++; $display("FAIL b2b_first_data got %h exp 55", tx_c[9:2]); end
        if (tx_c[11:10] !== 2'b01) begin
            n_fail++; $display("FAIL b2b_stop_start got %b exp 01", tx_c[11:10]);
        end
        if (tx_c[19:12] !== 8'hF0) begin n_fail++; $display("FAIL b2b_second_data got %h exp f0", tx_c[19:12]); end
        if (tx_c[20] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_stop got %b exp 1", tx_c[20]); end
    endtask

    task automatic test_two_stop();
        send_frame(1, 8'h00, 1'b0, 1'b0, 15);
        n_checks += 5;
        if (tx_c[11:1] !== 11'b110_0000_0000) begin
            n_fail++; $display("FAIL stop2_line got %b exp 11000000000", tx_c[11:1]);
        end
        if (rd_c[9] !== 1'b0) begin n_fail++; $display("FAIL stop2_ready_first got %b exp 0", rd_c[9]); end
        if (rd_c[10] !== 1'b1) begin n_fail++; $display("FAIL stop2_ready_final got %b exp 1", rd_c[10]); end
        if (bz_c[11] !== 1'b1) begin n_fail++; $display("FAIL stop2_busy_11 got %b exp 1", bz_c[11]); end
        if (bz_c[12] !== 1'b0) begin n_fail++; $display("FAIL stop2_busy_12 got %b exp 0", bz_c[12]); end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (exp_q[0].size() != 0 && guard < 50) begin step_cycle(); guard++; end
        dv[0] = 1'b1; p_data = 8'hFF; par_en = 1'b0; par_typ = 1'b0;
        step_cycle();
        dv[0] = 1'b0;
        for (int i = 0; i < 5; i++) step_cycle();
        #2 rst = 1'b1;
        #1;
        n_checks += 4;
        if (txo[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_tx got %b exp 1", txo[0]); end
        if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", bsy[0]); end
        if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b exp 1", rdy[0]); end
        if (en[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_ser_en got %b exp 0", en[0]); end
        step_cycle();
        rst = 1'b0;
        step_cycle();
        step_cycle();
        send_frame(0, 8'h81, 1'b0, 1'b0, 14);
        n_checks += 2;
        if (tx_c[10:1] !== {1'b1, 8'h81, 1'b0}) begin
            n_fail++; $display("FAIL midrst_next_frame got %b exp 1100000010", tx_c[10:1]);
        end
        if (bz_c[11] !== 1'b0) begin n_fail++; $display("FAIL midrst_next_busy got %b exp 0", bz_c[11]); end
    endtask

    task automatic test_hold();
        send_frame(0, 8'h3C, 1'b1, 1'b0, 15);
        n_checks += 4;
        if (pdata0 !== 8'h3C) begin n_fail++; $display("FAIL hold_pdata got %h exp 3c", pdata0); end
        if (tx_c[9:2] !== 8'h3C) begin n_fail++; $display("FAIL hold_data got %h exp 3c", tx_c[9:2]); end
        if (tx_c[10] !== 1'b0) begin n_fail++; $display("FAIL hold_parity got %b exp 0", tx_c[10]); end
        if (tx_c[11] !== 1'b1) begin n_fail++; $display("FAIL hold_stop got %b exp 1", tx_c[11]); end
    endtask

    initial begin
        dv = 2'b00; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_two_stop();
        test_reset_mid();
        test_hold();
        for (int i = 0; i < 4; i++) step_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
